// File: rtl/csa_pkg.sv
// csa_pkg: shared definitions for the carry-save accumulator.
//   state_t : FSM state encoding (ACCUM, RESOLVE, DONE).
//   nch()   : number of carry-propagate chunks, ACC_W / CHUNK.
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int nch(input int acc_w, input int chunk);
    return acc_w / chunk;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: combinational W-bit 3:2 compressor (carry-save adder).
//   a, b, c : three W-bit input vectors
//   sum     : bitwise sum vector
//   carry   : bitwise carry vector, NOT shifted; caller applies the << 1
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (carry[i])
    );
  end

endmodule

// File: rtl/full_adder.sv
// full_adder: gate-level 1-bit full adder cell.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: streaming multi-operand adder using carry-save arithmetic.
// Operands fold into a redundant S/C pair with one 3:2 compression per beat.
// On the last beat, the pair is resolved CHUNK bits per cycle into R.
//   clk, rst                    : clock, async active-high reset
//   in_valid/in_ready/in_data   : operand stream (WIDTH bits, zero-extended)
//   in_last                     : final operand of a burst
//   out_valid/out_ready         : result handshake
//   out_sum                     : burst sum mod 2^ACC_W
//   out_cnt                     : operand count mod 2^CNT_W
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int ACC_W = 8,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int NCH   = nch(ACC_W, CHUNK);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  state_t           state;
  logic [ACC_W-1:0] s_q, c_q, r_q;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cin;

  logic [ACC_W-1:0] x, csa_s, csa_c;
  logic [CHUNK-1:0] s_chunk, c_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sum   = r_q;
  assign out_cnt   = cnt;

  assign accept = in_valid && in_ready;
  assign x      = ACC_W'(in_data);

  csa_3to2 #(.W(ACC_W)) u_csa (
    .a     (s_q),
    .b     (c_q),
    .c     (x),
    .sum   (csa_s),
    .carry (csa_c)
  );

  // One chunk of the carry-propagate resolve.
  always_comb begin
    s_chunk   = s_q[idx*CHUNK +: CHUNK];
    c_chunk   = c_q[idx*CHUNK +: CHUNK];
    chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK+1)'(cin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      s_q   <= '0;
      c_q   <= '0;
      r_q   <= '0;
      cnt   <= '0;
      idx   <= '0;
      cin   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s_q <= csa_s;
            // Carry weight is one bit up; the bit shifted out is lost mod 2^ACC_W.
            c_q <= csa_c << 1;
            cnt <= cnt + CNT_W'(1);
            if (in_last) begin
              state <= RESOLVE;
              idx   <= '0;
              cin   <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_q[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          cin <= chunk_sum[CHUNK];
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= ACCUM;
            s_q   <= '0;
            c_q   <= '0;
            cnt   <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Streaming, parametrised multi-operand adder built on carry-save arithmetic. It accepts an arbitrary-length burst of WIDTH-bit unsigned operands over a valid/ready input. Each operand is folded into a redundant sum/carry pair with one 3:2 compression per cycle, so there is no carry propagation on the accumulate path. When the last operand arrives, the block resolves the redundant pair into a binary result CHUNK bits per cycle and presents it on a valid/ready output. It is the sequential, width-generic successor to the team's fixed four-operand 3-bit carry-save adder.

## Interface
- WIDTH, 3: operand width in bits.
- ACC_W, 8: accumulator and result width; all arithmetic is modulo 2^ACC_W; ACC_W >= WIDTH.
- CHUNK, 4: bits resolved per cycle in the carry-propagate phase; ACC_W % CHUNK == 0.
- CNT_W, 8: operand-counter width; the counter wraps modulo 2^CNT_W.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  unsigned operand; zero-extended to ACC_W.
- in_last  in  1  marks the final operand of a burst; sampled only on an accepted beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  binary sum of the burst, modulo 2^ACC_W.
- out_cnt  out  CNT_W  number of operands in the burst, modulo 2^CNT_W.

## Operation
- Internal state:
  - S and C, each ACC_W bits: redundant partial sum.
  - cnt, CNT_W bits: operand count.
  - idx: chunk index, 0..NCH-1, where NCH = ACC_W/CHUNK.
  - cin: 1-bit carry between chunks.
  - R, ACC_W bits: result register.
- FSM states: ACCUM, RESOLVE, DONE.
- ACCUM:
  - in_ready = 1.
  - On an accepted beat (in_valid && in_ready), with X = zero-extended in_data:
    - S <= S ^ C ^ X
    - C <= ((S&C)|(S&X)|(C&X)) << 1, truncated to ACC_W bits.
    - cnt <= cnt + 1.
  - Invariant: S + C ≡ running sum (mod 2^ACC_W).
  - If in_last is set on the accepted beat: go to RESOLVE with idx = 0 and cin = 0. The last beat is itself accumulated.
- RESOLVE:
  - in_ready = 0.
  - Each cycle, {cout, R[idx chunk]} <= S[idx chunk] + C[idx chunk] + cin, then cin <= cout and idx <= idx + 1.
  - After chunk NCH-1 is written: go to DONE. The final cout is discarded (modulo arithmetic).
- DONE:
  - in_ready = 0; out_valid = 1.
  - out_sum = R; out_cnt = cnt. Both are held stable while out_ready is low.
  - On out_valid && out_ready: go to ACCUM and clear S, C and cnt to 0.
- in_valid with in_ready low is ignored and not buffered.
- in_ready and out_valid are decoded from registered state only; there is no combinational input-to-output path.
- When not in_last, in_last is don't-care on non-accepted cycles.

## Timing
- Reset values while rst is high and immediately after:
  - state = ACCUM.
  - S = C = R = 0; cnt = idx = cin = 0.
  - in_ready = 1, out_valid = 0, out_sum = 0, out_cnt = 0.
- Accumulate throughput: one operand per cycle, no bubbles.
- Latency: out_valid rises NCH rising edges after the edge that accepts the in_last beat. Default NCH = 2.
- Back-to-back bursts:
  - The first beat of the next burst is accepted no earlier than the edge after the out_valid && out_ready handshake.
  - Minimum burst-to-burst gap is NCH + 1 cycles with out_ready tied high.
- A one-beat burst (in_last on the first beat) is legal: out_sum = in_data, out_cnt = 1.
- Counter wrap: with 2^CNT_W operands, out_cnt = 0. This is not an error.
- Reset asserted mid-RESOLVE or mid-DONE aborts the burst immediately. The result is never presented.

## Structure
- Shared package csa_pkg holds:
  - state encodings: ACCUM = 2'd0, RESOLVE = 2'd1, DONE = 2'd2.
  - the NCH derivation: ACC_W/CHUNK.
- One sub-module: csa_3to2 #(W), a combinational vector 3:2 compressor.
  - Outputs the sum vector and the carry vector, unshifted.
  - Built from the team's gate-level full_adder cell, replicated W times with a generate loop.
- The top level contains the FSM, the S/C/cnt registers and the chunked carry-propagate datapath.

## Test plan
Defaults unless stated: WIDTH=3, ACC_W=8, CHUNK=4.
1. Operands 7, 7, 7, 7, with in_last on the 4th -> out_valid 2 cycles later; out_sum = 28, out_cnt = 4.
2. Single beat 5 with in_last -> out_sum = 5, out_cnt = 1; in_ready is low for exactly 3 cycles including DONE with out_ready = 1.
3. 40 beats of 7 -> out_sum = 280 mod 256 = 24, out_cnt = 40. Also exercises carry propagation across the chunk boundary.
4. out_ready held low 5 cycles in DONE, with in_valid = 1 throughout:
   - out_sum and out_cnt stay stable and in_ready stays 0.
   - No beat is absorbed.
   - After the handshake, the next burst 1, 2 (last) yields 3.
5. rst pulsed during RESOLVE of burst 6, 6 (last):
   - out_valid never rises.
   - Outputs return to their reset values.
   - A following burst 3 (last) yields out_sum = 3, out_cnt = 1.
6. Parameter sweep WIDTH=8, ACC_W=16, CHUNK=4 with 300 random operands:
   - out_sum matches the reference sum mod 65536.
   - out_cnt = 300 mod 256 = 44.
   - Latency = 4 cycles.
